// File: rtl/fpu_frame_seq.sv
// fpu_frame_seq
// Command sequencer in front of a four-way single-precision FPU. Assembles
// 9-byte frames (opcode, A[31:0] MSB first, B[31:0] MSB first) from a byte
// receiver, holds the operands on the FPU inputs for LATENCY cycles, captures
// the result and streams it back as 4 bytes (MSB first) over valid/ready.
//
// state  | meaning
// IDLE   | waiting for an opcode byte; bytes with bits [7:2] != 0 are dropped
// GET_A  | shifting 4 bytes into fpu_a
// GET_B  | shifting 4 bytes into fpu_b
// WAIT   | counting LATENCY cycles for the FPU result
// SEND   | presenting result bytes 3..0 on tx_data
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data/rx_valid  received byte and one-cycle strobe (no backpressure)
//   rx_ready          high in IDLE/GET_A/GET_B
//   rx_overrun        sticky: byte arrived while rx_ready was low
//   fpu_op/a/b        opcode and operands to the FPU
//   fpu_result        FPU registered result
//   tx_data/valid/ready  response byte stream
//   busy              high in any state other than IDLE

module fpu_frame_seq #(
    parameter int LATENCY = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rx_overrun,
    output logic [1:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_result,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4
    } state_t;

    // Wait counter is loaded with LATENCY-1 so the capture lands exactly
    // LATENCY edges after the last frame byte.
    localparam logic [7:0]  LAT_LOAD = 8'(LATENCY - 1);
    // Timeout fires on the TIMEOUT-th idle edge after the last accepted byte.
    localparam logic [23:0] TO_LAST  = 24'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [7:0]  wait_cnt;
    logic [23:0] to_cnt;
    logic [31:0] tx_sh;

    assign tx_data = tx_sh[31:24];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            wait_cnt   <= '0;
            to_cnt     <= '0;
            tx_sh      <= '0;
            rx_ready   <= 1'b1;
            rx_overrun <= 1'b0;
            fpu_op     <= '0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (rx_valid && !rx_ready) begin
                rx_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data[7:2] == 6'd0)) begin
                        fpu_op   <= rx_data[1:0];
                        state    <= GET_A;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                    end
                end

                GET_A, GET_B: begin
                    // Timeout takes priority over a byte arriving on the same edge.
                    if (to_cnt == TO_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                    end else if (rx_valid) begin
                        to_cnt   <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == GET_A) begin
                            fpu_a <= {fpu_a[23:0], rx_data};
                            if (byte_cnt == 2'd3) begin
                                state <= GET_B;
                            end
                        end else begin
                            fpu_b <= {fpu_b[23:0], rx_data};
                            if (byte_cnt == 2'd3) begin
                                state    <= WAIT;
                                rx_ready <= 1'b0;
                                wait_cnt <= LAT_LOAD;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + 24'd1;
                    end
                end

                WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        tx_sh    <= fpu_result;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                SEND: begin
                    if (tx_valid && tx_ready) begin
                        tx_sh    <= {tx_sh[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    rx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_frame_seq.md
# fpu_frame_seq

Byte-stream command sequencer that sits directly upstream of the four-way floating-point unit (add / subtract / multiply / divide) and also collects its result. It assembles 9-byte command frames from the ESP32 link receiver into a 2-bit opcode and two IEEE-754 single-precision operands. It holds those operands stable on the FPU inputs for a fixed latency, then captures the 32-bit result and streams it back as 4 bytes over a valid/ready handshake.

## Interface
Parameters:
- LATENCY, 16, cycles from operands/opcode stable to `fpu_result` valid (FPU core latency plus output register); legal range 1..255
- TIMEOUT, 1000000, idle cycles allowed between bytes of a partial frame before it is discarded; legal 2..2^24-1

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure upstream
- rx_ready  out  1  high when a byte will be accepted (states IDLE, GET_A, GET_B)
- rx_overrun  out  1  sticky; set when `rx_valid` arrives while `rx_ready`=0; cleared only by rst
- fpu_op  out  2  opcode to FPU: 0 add, 1 subtract, 2 multiply, 3 divide
- fpu_a  out  32  operand A to FPU
- fpu_b  out  32  operand B to FPU
- fpu_result  in  32  FPU registered result
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid
- tx_ready  in  1  downstream accepts byte when `tx_valid` && `tx_ready`
- busy  out  1  high in any state other than IDLE

## Operation
- Frame format: byte 0 = opcode byte, bits [7:2] must be 0 and bits [1:0] form the op; bytes 1–4 = A, MSB first; bytes 5–8 = B, MSB first.
- Response: 4 bytes of the result, MSB first.
- States:
  - IDLE: accepts the opcode byte. If bits [7:2]≠0 the byte is dropped and the block stays in IDLE (resync). Otherwise it latches `fpu_op` and goes to GET_A.
  - GET_A: shifts 4 bytes into `fpu_a`, then goes to GET_B.
  - GET_B: shifts 4 bytes into `fpu_b`. On the 4th byte it goes to WAIT and loads the wait counter.
  - WAIT: counts LATENCY cycles. On the last count it captures `fpu_result` into the tx shift register and goes to SEND.
  - SEND: presents bytes 3..0 of the captured result. It advances on each handshake and returns to IDLE after the 4th handshake.
- `fpu_op`, `fpu_a` and `fpu_b` change only on accepted frame bytes. They hold their last values through WAIT, SEND and IDLE.
- Byte counter: 2 bits, shared by GET_A, GET_B and SEND; wraps 3→0 on state change.
- Timeout counter:
  - Cleared on every accepted byte.
  - Counts only in GET_A and GET_B.
  - On reaching TIMEOUT: return to IDLE and discard the partial frame; `fpu_a`/`fpu_b` may hold partial shifts.
- A byte accepted in the same cycle the timeout fires is ignored (timeout wins).
- `rx_valid` while `rx_ready`=0 (WAIT, SEND) drops the byte and sets `rx_overrun`.
- Reset mid-operation aborts any frame or response immediately. No partial response is completed.

## Timing
- Reset values: `rx_ready`=1, `rx_overrun`=0, `fpu_op`=0, `fpu_a`=0, `fpu_b`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, state IDLE, all counters 0.
- The 9th byte is accepted at edge N. From edge N:
  - `fpu_b` holds its final value; `busy`=1 and `rx_ready`=0.
  - `fpu_result` is sampled at edge N+LATENCY.
  - `tx_valid`=1 with the MSB byte from edge N+LATENCY.
- With `tx_ready` held at 1, bytes transfer on edges N+LATENCY+1..N+LATENCY+4.
- `tx_valid`=0, `rx_ready`=1 and `busy`=0 from edge N+LATENCY+4.
- Minimum frame-to-frame period: 9 + LATENCY + 4 cycles.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` must not change and `tx_valid` must not drop.
- `tx_valid` does not depend combinationally on `tx_ready`.
- `rx_ready` is a registered/state-decoded output with no combinational path from `rx_valid`.

## Test plan
- Add, `tx_ready`=1: send 00 3F 80 00 00 40 00 00 00 with the FPU model returning 1.0+2.0 -> `fpu_op`=0, `fpu_a`=0x3F800000, `fpu_b`=0x40000000; tx bytes 40 40 00 00 at the exact cycles above.
- Multiply with backpressure: send 02 40 40 00 00 40 00 00 00; hold `tx_ready`=0 for 5 cycles while byte 2 is presented -> tx bytes 40 C0 00 00; `tx_data` stable at C0 throughout the stall.
- Resync: send 85, then a valid subtract frame 01 40 A0 00 00 3F 80 00 00 -> 0x85 is dropped; exactly one response, 40 80 00 00.
- Timeout: send 03 3F 80 00, idle TIMEOUT cycles, then a full divide frame 03 41 20 00 00 40 00 00 00 -> the partial frame is discarded; response 40 A0 00 00 only.
- Overrun: pulse `rx_valid` during WAIT -> `rx_overrun`=1 and stays 1; the response is unaffected.
- Reset during SEND, after 2 bytes transferred -> next cycle `tx_valid`=0, `busy`=0, all outputs at reset values; the next frame processes normally.
